// File: rtl/serial_mod_pkg.sv
// Shared types and elaboration-time helpers for the serial remainder engine.
package serial_mod_pkg;

    // Operating mode, latched on clear.
    typedef enum logic {
        MODE_CUM   = 1'b0,   // remainder of the whole stream since clear
        MODE_SLIDE = 1'b1    // remainder of the last WIN bits only
    } mode_e;

    // 2^win_len mod modulus, evaluated at elaboration so no hardware results.
    function automatic int pow2_mod(input int win_len, input int modulus);
        int r;
        r = 1 % modulus;
        for (int i = 0; i < win_len; i++) begin
            r = (r * 2) % modulus;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_mod_rem_mod_step.sv
// Single-bit remainder step: r' = (2r + b - d*W2) mod MOD, built only from
// compares, subtracts and adds so no divider or multiplier appears.
module mod_step #(
    parameter int MOD = 7,
    parameter int W2  = 2,
    localparam int RW = $clog2(MOD)
) (
    input  logic [RW-1:0] r,
    input  logic          b,
    input  logic          d,
    input  logic          en_sub,
    output logic [RW-1:0] r_next
);

    localparam logic [RW:0]   MOD_W   = (RW+1)'(MOD);
    localparam logic [RW-1:0] W2_R    = RW'(W2);
    // Only used when the value is below W2, so it always lands below MOD.
    localparam logic [RW-1:0] MOD_M_W = RW'(MOD - W2);

    logic [RW:0]   sum;
    logic [RW-1:0] sum_red;

    // Shift in the new bit, fold once into range, then remove the departing bit's weight.
    always_comb begin
        // NOTE: every signal gets a value on every path so no latch is inferred.
        sum     = {r, b};
        sum_red = sum[RW-1:0];
        r_next  = sum_red;
        // r < MOD makes 2r+b <= 2*MOD-1, so a single subtract suffices.
        if (sum >= MOD_W) begin
            sum_red = RW'(sum - MOD_W);
        end
        r_next = sum_red;
        if (en_sub && d) begin
            if (sum_red >= W2_R) begin
                r_next = sum_red - W2_R;
            end else begin
                r_next = sum_red + MOD_M_W;
            end
        end
    end

endmodule

// File: rtl/serial_mod_rem.sv
// Serial remainder engine: one bit per accepted cycle, MSB-first, tracking the
// value modulo MOD either cumulatively or over a sliding window of WIN bits.
// Optional SERIAL_MOD_STATS_EN adds hit_cnt, a saturating count of accepted
// bits that left the remainder at zero.
module serial_mod_rem
    import serial_mod_pkg::*;
#(
    parameter int MOD = 7,
    parameter int WIN = 16,
    localparam int RW = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          mode,
    input  logic          in_valid,
    input  logic          data_in,
    output logic [RW-1:0] rem_out,
    output logic          rem_valid,
    output logic          divisible,
    output logic          win_full
`ifdef SERIAL_MOD_STATS_EN
    ,output logic [15:0]  hit_cnt
`endif
);

    localparam int            CW    = $clog2(WIN + 1);
    localparam int            W2    = pow2_mod(WIN, MOD);
    localparam logic [CW-1:0] WIN_C = CW'(WIN);

    mode_e           mode_q;
    logic [WIN-1:0]  win_sr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [RW-1:0]   rem_next;
    logic            accept;

    assign accept = in_valid && !clear;

    // Bit at the top of the window is the one accepted WIN accepts ago
    // (a reset zero until the window has filled).
    mod_step #(
        .MOD (MOD),
        .W2  (W2)
    ) u_step (
        .r      (rem_out),
        .b      (data_in),
        .d      (win_sr[WIN-1]),
        .en_sub (mode_q == MODE_SLIDE),
        .r_next (rem_next)
    );

    // Fill counter saturates at WIN so long streams never wrap.
    always_comb begin
        cnt_next = (cnt == WIN_C) ? cnt : cnt + CW'(1);
    end

    // Remainder, window and status registers; clear restarts and latches mode.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            rem_out   <= '0;
            rem_valid <= 1'b0;
            divisible <= 1'b1;
            win_full  <= 1'b0;
            win_sr    <= '0;
            cnt       <= '0;
            mode_q    <= MODE_CUM;
        end else if (clear) begin
            rem_out   <= '0;
            rem_valid <= 1'b0;
            divisible <= 1'b1;
            win_full  <= 1'b0;
            win_sr    <= '0;
            cnt       <= '0;
            mode_q    <= mode_e'(mode);
        end else if (in_valid) begin
            rem_out   <= rem_next;
            rem_valid <= 1'b1;
            divisible <= (rem_next == '0);
            win_full  <= (cnt_next == WIN_C);
            win_sr    <= {win_sr[WIN-2:0], data_in};
            cnt       <= cnt_next;
        end else begin
            rem_valid <= 1'b0;
        end
    end

`ifdef SERIAL_MOD_STATS_EN
    // Count accepted bits that leave the remainder at zero, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt <= '0;
        end else if (clear) begin
            hit_cnt <= '0;
        end else if (accept && (rem_next == '0) && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end
`endif

endmodule
